// File: rtl/i_mem_fill_ctrl_if.sv
// Fill-request / line-response bundle between the I-cache miss path and the fill controller.
// master = cache side (issues requests, sees responses), slave = fill controller.
interface i_mem_fill_ctrl_if #(
  parameter int CL_WIDTH    = 128,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                flush;
  logic                req_valid;
  logic [31:0]         req_address;
  logic                req_ready;
  logic                rsp_valid;
  logic [31:0]         rsp_address;
  logic [CL_WIDTH-1:0] rsp_data;
  logic [CNT_W-1:0]    pending_count;

  modport master (
    output flush, req_valid, req_address,
    input  req_ready, rsp_valid, rsp_address, rsp_data, pending_count
  );

  modport slave (
    input  flush, req_valid, req_address,
    output req_ready, rsp_valid, rsp_address, rsp_data, pending_count
  );
endinterface

// File: rtl/i_mem_fill_ctrl.sv
// In-order instruction line fill from an internal ROM; response IMEM_LATENCY cycles after acceptance.
// Backpressure: req_ready low when QUEUE_DEPTH requests are pending or during flush/reset.
module i_mem_fill_ctrl #(
  parameter int CL_WIDTH     = 128,
  parameter int IMEM_LATENCY = 8,
  parameter int QUEUE_DEPTH  = 4,
  parameter int MEM_LINES    = 1024
) (
  input logic              clk,
  input logic              rst,
  i_mem_fill_ctrl_if.slave bus
);
  localparam int OFFSET_BITS = $clog2(CL_WIDTH / 8);
  localparam int IDX_BITS    = $clog2(MEM_LINES);
  localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1;
  localparam int PTR_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int TMR_W       = $clog2(IMEM_LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [CL_WIDTH-1:0] mem [MEM_LINES];
  logic [31:0]         q_addr [QUEUE_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [TMR_W-1:0]    timer;
  state_t              state;
  logic                push, pop;
  logic [31:0]         head_addr;
  logic [IDX_BITS-1:0] head_idx;

  assign bus.req_ready = !rst && !bus.flush && (count < CNT_W'(QUEUE_DEPTH));
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == BUSY) && (timer == TMR_W'(IMEM_LATENCY)) && !bus.flush && !rst;
  assign count_nxt     = count + CNT_W'(push) - CNT_W'(pop);

  assign head_addr = q_addr[rd_ptr];
  assign head_idx  = head_addr[OFFSET_BITS +: IDX_BITS];

  assign bus.rsp_valid     = pop;
  assign bus.rsp_address   = pop ? head_addr : 32'd0;
  assign bus.rsp_data      = pop ? mem[head_idx] : '0;
  assign bus.pending_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.req_address;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
      timer  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      case (state)
        IDLE: begin
          // An entry pushed on this edge counts, so an idle block answers at T+IMEM_LATENCY.
          if (count_nxt != '0) begin
            state <= BUSY;
            timer <= TMR_W'(1);
          end
        end
        BUSY: begin
          if (pop) begin
            // Next head starts on the pop edge, spacing responses IMEM_LATENCY apart.
            if (count_nxt != '0) begin
              timer <= TMR_W'(1);
            end else begin
              state <= IDLE;
              timer <= '0;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i_mem_fill_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses, negedge monitors pop and compare.
module tb_i_mem_fill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
    int           cyc;
  } exp_t;

  exp_t exp1[$];
  exp_t exp2[$];

  i_mem_fill_ctrl_if #(.CL_WIDTH(128), .QUEUE_DEPTH(4)) bus ();
  i_mem_fill_ctrl_if #(.CL_WIDTH(256), .QUEUE_DEPTH(1)) bus2 ();

  i_mem_fill_ctrl #(.CL_WIDTH(128), .IMEM_LATENCY(8), .QUEUE_DEPTH(4), .MEM_LINES(1024))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  i_mem_fill_ctrl #(.CL_WIDTH(256), .IMEM_LATENCY(2), .QUEUE_DEPTH(1), .MEM_LINES(1024))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] line128(input int k);
    logic [31:0] w;
    w = 32'h5A00_0000 + 32'(k);
    return (k == 3) ? {16{8'hA5}} : {4{w}};
  endfunction

  function automatic logic [255:0] line256(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(k);
    return {8{w}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push1(input logic [31:0] a, input int line, input int c);
    exp_t e;
    e.addr = a;
    e.data = {128'd0, line128(line)};
    e.cyc  = c;
    exp1.push_back(e);
  endtask

  task automatic send(input logic [31:0] a, output int t);
    int n = 0;
    t = -1;
    bus.req_valid   = 1'b1;
    bus.req_address = a;
    while (t < 0 && n < 100) begin
      @(negedge clk);
      if (bus.req_ready) t = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (t < 0) chk("send_accept_timeout", {255'd0, bus.req_ready}, 256'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid) begin
        chk("rsp1_expected", {255'd0, exp1.size() > 0}, 256'd1);
        if (exp1.size() > 0) begin
          exp_t e;
          e = exp1.pop_front();
          chk("rsp1_addr", bus.rsp_address, e.addr);
          chk("rsp1_data", bus.rsp_data, e.data);
          chk("rsp1_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle1_addr_zero", bus.rsp_address, 256'd0);
        chk("idle1_data_zero", bus.rsp_data, 256'd0);
      end
      if (bus2.rsp_valid) begin
        chk("rsp2_expected", {255'd0, exp2.size() > 0}, 256'd1);
        if (exp2.size() > 0) begin
          exp_t e;
          e = exp2.pop_front();
          chk("rsp2_addr", bus2.rsp_address, e.addr);
          chk("rsp2_data", bus2.rsp_data, e.data);
          chk("rsp2_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int t0, t1, t2, t3, t4;
    exp_t e;
    bus.flush = 1'b0;  bus.req_valid = 1'b0;  bus.req_address = 32'd0;
    bus2.flush = 1'b0; bus2.req_valid = 1'b0; bus2.req_address = 32'd0;
    for (int i = 0; i < 16; i++) begin
      u_dut.mem[i]  = line128(i);
      u_dut2.mem[i] = line256(i);
    end

    // reset
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("ready_in_reset", {255'd0, bus.req_ready}, 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {255'd0, bus.req_ready}, 256'd1);
    chk("reset_rsp_valid", {255'd0, bus.rsp_valid}, 256'd0);
    chk("reset_rsp_addr", bus.rsp_address, 256'd0);
    chk("reset_rsp_data", bus.rsp_data, 256'd0);
    chk("reset_pending", bus.pending_count, 256'd0);
    chk("reset_pending2", bus2.pending_count, 256'd0);

    // single request, line 3
    goto(cyc + 1);
    send(32'h0000_0034, t0);
    push1(32'h34, 3, t0 + 8);
    goto(t0 + 1);
    @(negedge clk);
    chk("single_pending_1", bus.pending_count, 256'd1);
    goto(t0 + 9);
    @(negedge clk);
    chk("single_pending_0", bus.pending_count, 256'd0);

    // burst of four, then a fifth held while full
    goto(cyc + 2);
    send(32'h10, t0);
    send(32'h20, t1);
    send(32'h30, t2);
    send(32'h40, t3);
    chk("burst_back_to_back", t3, t0 + 3);
    push1(32'h10, 1, t0 + 8);
    push1(32'h20, 2, t0 + 16);
    push1(32'h30, 3, t0 + 24);
    push1(32'h40, 4, t0 + 32);
    bus.req_valid = 1'b1;
    bus.req_address = 32'h50;
    @(negedge clk);
    chk("full_ready_low", {255'd0, bus.req_ready}, 256'd0);
    chk("full_pending_4", bus.pending_count, 256'd4);
    @(posedge clk);
    #1;
    send(32'h50, t4);
    chk("fifth_accept_cycle", t4, t0 + 9);
    push1(32'h50, 5, t0 + 40);
    goto(t0 + 41);
    @(negedge clk);
    chk("burst_pending_0", bus.pending_count, 256'd0);

    // flush five cycles into service with three pending
    goto(cyc + 2);
    send(32'h60, t0);
    send(32'h70, t1);
    send(32'h80, t2);
    goto(t0 + 5);
    bus.flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_address = 32'h90;
    @(negedge clk);
    chk("flush_ready_low", {255'd0, bus.req_ready}, 256'd0);
    chk("flush_pending_before", bus.pending_count, 256'd3);
    goto(t0 + 6);
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("flush_pending_0", bus.pending_count, 256'd0);
    goto(t0 + 8);
    send(32'hB0, t3);
    push1(32'hB0, 11, t3 + 8);
    goto(t3 + 9);
    @(negedge clk);
    chk("post_flush_pending_0", bus.pending_count, 256'd0);

    // flush in the response cycle
    goto(cyc + 2);
    send(32'hC0, t4);
    goto(t4 + 8);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_at_rsp_valid_low", {255'd0, bus.rsp_valid}, 256'd0);
    goto(t4 + 9);
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_at_rsp_pending_0", bus.pending_count, 256'd0);
    goto(t4 + 20);

    // small configuration: latency 2, depth 1, 32-byte lines
    goto(cyc + 1);
    bus2.req_valid = 1'b1;
    bus2.req_address = 32'h0000_0040;
    @(negedge clk);
    chk("p2_ready_idle", {255'd0, bus2.req_ready}, 256'd1);
    t0 = cyc;
    e.addr = 32'h40; e.data = line256(2); e.cyc = t0 + 2;
    exp2.push_back(e);
    @(posedge clk);
    #1;
    bus2.req_address = 32'h0000_0060;
    @(negedge clk);
    chk("p2_ready_full_t1", {255'd0, bus2.req_ready}, 256'd0);
    chk("p2_pending_1", bus2.pending_count, 256'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("p2_ready_full_t2", {255'd0, bus2.req_ready}, 256'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("p2_ready_after_pop", {255'd0, bus2.req_ready}, 256'd1);
    e.addr = 32'h60; e.data = line256(3); e.cyc = t0 + 5;
    exp2.push_back(e);
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b0;

    goto(cyc + 12);
    @(negedge clk);
    chk("scoreboard1_drained", exp1.size(), 256'd0);
    chk("scoreboard2_drained", exp2.size(), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
